// File: rtl/inequality_monitor_if.sv
// Handshake bundle for the inequality monitor stage.
// Upstream pair offer plus downstream registered result.
interface inequality_monitor_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_not_equal;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_diff, out_not_equal
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_diff, out_not_equal
    );
endinterface

// File: rtl/inequality_monitor.sv
// Buffered bitwise inequality stage with valid/ready flow control,
// saturating pair/mismatch counters and a sticky mismatch-run alarm.
module inequality_monitor #(
    parameter int WIDTH     = 5,
    parameter int CNT_W     = 8,
    parameter int ALARM_RUN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    inequality_monitor_if.slave  bus,
    output logic [CNT_W-1:0]     pair_count,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic                 alarm
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(ALARM_RUN);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] diff;
    logic             ne;
    logic [CNT_W-1:0] run;

    assign diff   = bus.a ^ bus.b;
    assign ne     = |diff;
    assign accept = bus.in_valid & bus.in_ready;

    // Stage state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state: clear wins, an accept refills, a lone consume drains.
    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = FULL;
        else if (state == FULL && bus.out_ready)
            state_nxt = EMPTY;
    end

    // Handshake outputs derived from state.
    always_comb begin
        bus.out_valid = (state == FULL);
        bus.in_ready  = ~clear & ((state == EMPTY) | bus.out_ready);
    end

    // Result register, loaded only on accept and held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_diff      <= '0;
            bus.out_not_equal <= 1'b0;
        end else if (accept) begin
            bus.out_diff      <= diff;
            bus.out_not_equal <= ne;
        end
    end

    // Saturating counters of accepted and differing pairs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pair_count     <= '0;
            mismatch_count <= '0;
        end else if (clear) begin
            pair_count     <= '0;
            mismatch_count <= '0;
        end else if (accept) begin
            if (pair_count != CNT_MAX)
                pair_count <= pair_count + ONE;
            if (ne && mismatch_count != CNT_MAX)
                mismatch_count <= mismatch_count + ONE;
        end
    end

    // Mismatch run tracker and sticky alarm.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run   <= '0;
            alarm <= 1'b0;
        end else if (clear) begin
            run   <= '0;
            alarm <= 1'b0;
        end else if (accept) begin
            if (!ne) begin
                run <= '0;
            end else begin
                if (run < RUN_MAX)
                    run <= run + ONE;
                if (run >= RUN_MAX - ONE)
                    alarm <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inequality_monitor.sv
// Randomized and directed bench for inequality_monitor.
// Main instance uses defaults; a second uses CNT_W=3 for saturation.
module tb_inequality_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, clr0, clr1;
    logic [7:0] pc0, mc0;
    logic [2:0] pc1, mc1;
    logic       al0, al1;

    inequality_monitor_if #(.WIDTH(5)) m_if ();
    inequality_monitor_if #(.WIDTH(5)) s_if ();

    inequality_monitor #(.WIDTH(5), .CNT_W(8), .ALARM_RUN(3)) dut (
        .clk(clk), .reset(rst0), .clear(clr0), .bus(m_if.slave),
        .pair_count(pc0), .mismatch_count(mc0), .alarm(al0)
    );

    inequality_monitor #(.WIDTH(5), .CNT_W(3), .ALARM_RUN(3)) u_sat (
        .clk(clk), .reset(rst1), .clear(clr1), .bus(s_if.slave),
        .pair_count(pc1), .mismatch_count(mc1), .alarm(al1)
    );

    int pass_cnt = 0;
    int total    = 0;

    // Reference model state, in terms of the behavioural rules.
    bit       md_full;
    bit [4:0] md_diff;
    bit       md_ne;
    int       md_pairs, md_mism, md_run;
    bit       md_alarm;

    bit       cur_iv, cur_ordy, cur_clr;
    bit [4:0] cur_a, cur_b;

    function automatic bit md_ready();
        return !cur_clr && (!md_full || cur_ordy);
    endfunction

    task automatic drive(input bit iv, input bit [4:0] av, input bit [4:0] bv,
                         input bit ordy, input bit clr);
        cur_iv = iv; cur_a = av; cur_b = bv; cur_ordy = ordy; cur_clr = clr;
        m_if.in_valid = iv; m_if.a = av; m_if.b = bv;
        m_if.out_ready = ordy; clr0 = clr;
        #1;
    endtask

    task automatic tick();
        bit acc;
        acc = cur_iv && md_ready();
        @(posedge clk);
        #1;
        if (cur_clr) begin
            md_full = 0; md_pairs = 0; md_mism = 0;
            md_run = 0; md_alarm = 0;
        end else if (acc) begin
            md_full = 1;
            md_diff = cur_a ^ cur_b;
            md_ne = (cur_a != cur_b);
            if (md_pairs < 255) md_pairs++;
            if (md_ne) begin
                if (md_mism < 255) md_mism++;
                if (md_run < 3) md_run++;
                if (md_run == 3) md_alarm = 1;
            end else begin
                md_run = 0;
            end
        end else if (md_full && cur_ordy) begin
            md_full = 0;
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1, 0);
        rst0 = 1;
        #3;
        rst0 = 0;
        md_full = 0; md_diff = 0; md_ne = 0;
        md_pairs = 0; md_mism = 0; md_run = 0; md_alarm = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1;
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        total++;
        if ({m_if.out_valid, m_if.out_diff, m_if.out_not_equal, pc0, mc0, al0}
            !== 24'h0)
            $display("FAIL reset: got v=%b d=%b ne=%b pc=%0d mc=%0d al=%b want all 0",
                     m_if.out_valid, m_if.out_diff, m_if.out_not_equal, pc0, mc0, al0);
        else pass_cnt++;
        rst0 = 0;
    endtask

    task automatic test_equal_pair();
        do_reset();
        drive(1, 5'b10101, 5'b10101, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        total++;
        if ({m_if.out_valid, m_if.out_not_equal, m_if.out_diff} !== {1'b1, 1'b0, 5'b0})
            $display("FAIL equal_out: got v=%b ne=%b d=%b want 1 0 00000",
                     m_if.out_valid, m_if.out_not_equal, m_if.out_diff);
        else pass_cnt++;
        total++;
        if (pc0 !== 8'd1 || mc0 !== 8'd0)
            $display("FAIL equal_cnt: got pc=%0d mc=%0d want 1 0", pc0, mc0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit [4:0] av [3] = '{5'b11111, 5'b01110, 5'b11100};
        bit [4:0] bv [3] = '{5'b00001, 5'b01110, 5'b11101};
        bit [4:0] ed [3] = '{5'b11110, 5'b00000, 5'b00001};
        bit       en [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, av[i], bv[i], 1, 0);
            total++;
            if (m_if.in_ready !== 1'b1)
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, m_if.in_ready);
            else pass_cnt++;
            tick();
            total++;
            if (m_if.out_diff !== ed[i] || m_if.out_not_equal !== en[i]
                || m_if.out_valid !== 1'b1)
                $display("FAIL b2b_out[%0d]: got d=%b ne=%b v=%b want d=%b ne=%b v=1",
                         i, m_if.out_diff, m_if.out_not_equal, m_if.out_valid,
                         ed[i], en[i]);
            else pass_cnt++;
        end
        drive(0, 0, 0, 1, 0);
        total++;
        if (pc0 !== 8'd3 || mc0 !== 8'd2 || al0 !== 1'b0)
            $display("FAIL b2b_cnt: got pc=%0d mc=%0d al=%b want 3 2 0", pc0, mc0, al0);
        else pass_cnt++;
    endtask

    task automatic test_alarm();
        bit [4:0] bv [3] = '{5'b00001, 5'b00010, 5'b00100};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'b0, bv[i], 1, 0);
            tick();
            total++;
            if (al0 !== (i == 2))
                $display("FAIL alarm_run[%0d]: got %b want %b", i, al0, (i == 2));
            else pass_cnt++;
        end
        drive(1, 5'b01010, 5'b01010, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        total++;
        if (al0 !== 1'b1 || m_if.out_not_equal !== 1'b0)
            $display("FAIL alarm_sticky: got al=%b ne=%b want 1 0", al0, m_if.out_not_equal);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit [4:0] held;
        do_reset();
        drive(1, 5'b10000, 5'b00011, 1, 0);
        tick();
        held = 5'b10011;
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'b00110, 5'b00101, 0, 0);
            total++;
            if (m_if.in_ready !== 1'b0 || m_if.out_diff !== held
                || m_if.out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got rdy=%b d=%b v=%b want 0 %b 1",
                         i, m_if.in_ready, m_if.out_diff, m_if.out_valid, held);
            else pass_cnt++;
            tick();
        end
        drive(1, 5'b00110, 5'b00101, 1, 0);
        total++;
        if (m_if.in_ready !== 1'b1)
            $display("FAIL bp_release: got rdy=%b want 1", m_if.in_ready);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 1, 0);
        total++;
        if (m_if.out_diff !== 5'b00011 || m_if.out_valid !== 1'b1 || pc0 !== 8'd2)
            $display("FAIL bp_new: got d=%b v=%b pc=%0d want 00011 1 2",
                     m_if.out_diff, m_if.out_valid, pc0);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        bit [4:0] bv [5] = '{5'b00001, 5'b00010, 5'b00100, 5'b00000, 5'b00000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'b0, bv[i], 1, 0);
            tick();
        end
        drive(1, 5'b11000, 5'b01000, 1, 1);
        total++;
        if (pc0 !== 8'd5 || mc0 !== 8'd3 || al0 !== 1'b1 || m_if.in_ready !== 1'b0)
            $display("FAIL clear_pre: got pc=%0d mc=%0d al=%b rdy=%b want 5 3 1 0",
                     pc0, mc0, al0, m_if.in_ready);
        else pass_cnt++;
        tick();
        drive(1, 5'b11000, 5'b01000, 1, 0);
        total++;
        if (pc0 !== 8'd0 || mc0 !== 8'd0 || al0 !== 1'b0 || m_if.out_valid !== 1'b0)
            $display("FAIL clear_post: got pc=%0d mc=%0d al=%b v=%b want 0 0 0 0",
                     pc0, mc0, al0, m_if.out_valid);
        else pass_cnt++;
        tick();
        drive(0, 0, 0, 1, 0);
        total++;
        if (m_if.out_valid !== 1'b1 || m_if.out_diff !== 5'b10000 || pc0 !== 8'd1)
            $display("FAIL clear_held: got v=%b d=%b pc=%0d want 1 10000 1",
                     m_if.out_valid, m_if.out_diff, pc0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) cur_b = cur_a ^ (5'd1 << $urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) cur_b = cur_a;
            m_if.b = cur_b;
            #1;
            total++;
            if (m_if.in_ready !== md_ready()) begin
                errs++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, m_if.in_ready, md_ready());
            end else pass_cnt++;
            tick();
            total++;
            if (m_if.out_valid !== md_full || m_if.out_diff !== md_diff
                || m_if.out_not_equal !== md_ne || pc0 !== 8'(md_pairs)
                || mc0 !== 8'(md_mism) || al0 !== md_alarm) begin
                errs++;
                $display("FAIL rand_state[%0d]: got v=%b d=%b ne=%b pc=%0d mc=%0d al=%b want %b %b %b %0d %0d %b",
                         i, m_if.out_valid, m_if.out_diff, m_if.out_not_equal, pc0, mc0, al0,
                         md_full, md_diff, md_ne, md_pairs, md_mism, md_alarm);
            end else pass_cnt++;
            if (errs > 5) break;
        end
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_saturation();
        rst1 = 1;
        #3;
        rst1 = 0;
        for (int i = 0; i < 9; i++) begin
            s_if.in_valid = 1; s_if.a = 5'(i); s_if.b = 5'(i) ^ 5'b10000;
            s_if.out_ready = 1;
            @(posedge clk);
            #1;
        end
        total++;
        if (pc1 !== 3'd7 || mc1 !== 3'd7 || al1 !== 1'b1)
            $display("FAIL sat_cnt: got pc=%0d mc=%0d al=%b want 7 7 1", pc1, mc1, al1);
        else pass_cnt++;
        rst1 = 1;
        #2;
        total++;
        if ({s_if.out_valid, s_if.out_diff, s_if.out_not_equal, pc1, mc1, al1} !== 14'h0)
            $display("FAIL sat_async_rst: got v=%b d=%b ne=%b pc=%0d mc=%0d al=%b want all 0",
                     s_if.out_valid, s_if.out_diff, s_if.out_not_equal, pc1, mc1, al1);
        else pass_cnt++;
        s_if.in_valid = 0;
        @(posedge clk);
        #1;
        rst1 = 0;
    endtask

    initial begin
        rst1 = 1; clr1 = 0;
        s_if.in_valid = 0; s_if.a = 0; s_if.b = 0; s_if.out_ready = 1;
        test_reset();
        test_equal_pair();
        test_back_to_back();
        test_alarm();
        test_backpressure();
        test_clear();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/inequality_monitor.md
Name: inequality_monitor

Overview:
- Sequential stage that consumes pairs of WIDTH-bit words, compares them bitwise (XOR mask, then OR-reduce to not_equal), and presents the registered result downstream with a valid/ready handshake.
- Keeps saturating pair and mismatch counters.
- Raises a sticky alarm when ALARM_RUN consecutive accepted pairs all differ.
- Sits directly downstream of the operand source and wraps the 5-bit inequality comparison in a buffered, flow-controlled stage.

Parameters:
- WIDTH, 5: operand width in bits.
- CNT_W, 8: width of the pair and mismatch counters.
- ALARM_RUN, 3: consecutive mismatches that set the alarm. Legal range is 1 to 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clear  input  1  synchronous, active-high soft clear.
- in_valid  input  1  upstream offers a pair.
- in_ready  output  1  stage can accept a pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  registered result present.
- out_ready  input  1  downstream consumes the result.
- out_diff  output  WIDTH  registered a^b mask.
- out_not_equal  output  1  registered OR-reduction of out_diff.
- pair_count  output  CNT_W  accepted pairs, saturating.
- mismatch_count  output  CNT_W  accepted differing pairs, saturating.
- alarm  output  1  sticky run-of-mismatches flag.

Behaviour:
- Reset (asynchronous, active-high), values while asserted and after release:
  - out_valid=0, out_diff=0, out_not_equal=0.
  - pair_count=0, mismatch_count=0, run counter=0, alarm=0.
  - FSM=EMPTY.
- FSM has 2 states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- in_ready = ~clear & (EMPTY | out_ready). This is combinational and allows back-to-back throughput of 1 pair/cycle.
- Accept when in_valid & in_ready. On the next edge:
  - out_diff <= a^b.
  - out_not_equal <= |(a^b).
  - FSM -> FULL.
  - Latency: exactly 1 cycle from accept to out_valid.
- FULL & out_ready & no accept -> EMPTY.
- FULL & out_ready & accept -> stays FULL with new data.
- FULL & ~out_ready: out_diff and out_not_equal are held stable, and in_ready=0.
- Counters, on accept only:
  - pair_count += 1, saturating at 2^CNT_W-1.
  - mismatch_count += 1 if a!=b, same saturation.
- Run counter, on accept:
  - Mismatch: run += 1, saturating at ALARM_RUN.
  - Equal pair: run <= 0.
- Alarm:
  - Set on the edge where run reaches ALARM_RUN.
  - Sticky until clear or reset. A later equal pair does not drop it.
- clear = 1:
  - Next edge zeroes both counters, the run counter and alarm.
  - Drops out_valid (FSM -> EMPTY).
  - in_ready=0 that cycle, so a simultaneous in_valid pair is not accepted; upstream must hold it.
- Simultaneous accept and consume in FULL: the consume takes effect first and the new pair is loaded. Nothing is lost or duplicated.
- Counters reflect accepted pairs, not consumed results. They update on the same edge that loads out_diff.
- Reset mid-transfer discards the buffered result. No partial state survives.

Test Plan:
- Reset released, then a=10101, b=10101, in_valid=1 for one cycle, out_ready=1. Required on the next cycle:
  - out_valid=1, out_not_equal=0, out_diff=00000.
  - pair_count=1, mismatch_count=0.
- Back-to-back pairs (11111,00001), (01110,01110), (11100,11101), with out_ready=1. Required:
  - out_diff sequence is 11110, 00000, 00001.
  - not_equal sequence is 1, 0, 1.
  - in_ready stays 1.
  - Final counts are pair=3, mismatch=2.
  - alarm=0, because the run was broken by the equal pair.
- Three consecutive differing pairs (00000,00001), (00000,00010), (00000,00100). Required:
  - alarm=1 on the edge accepting the third pair.
  - A following equal pair leaves alarm=1.
- Backpressure: result FULL, out_ready=0 for 4 cycles, in_valid=1 with a new pair. Required:
  - in_ready=0 and out_diff is unchanged for all 4 cycles.
  - When out_ready=1, the new pair is accepted that same cycle and appears on the next cycle.
  - pair_count is incremented exactly once.
- clear asserted in the same cycle as a valid pair, with counters at pair=5, mismatch=3, alarm=1. Required:
  - in_ready=0 that cycle.
  - Next cycle: all counters 0, alarm=0, out_valid=0.
  - The held pair is accepted the cycle after clear deasserts.
- Saturation with CNT_W=3: feed 9 differing pairs. Required:
  - pair_count=7 and mismatch_count=7, with no wrap.
  - Assert reset asynchronously mid-stream: all outputs go to 0 without waiting for a clock edge.
